// File: rtl/sevenseg_scan_decoder_pkg.sv
// Shared 7-segment display definitions.
// Segment ordering: bit0 = a ... bit6 = g, active-low (0 lights the segment).
// Provides the hex-to-segment table used by both the encoder and the scan decoder,
// the frame FSM state type and the digit-select decode helper.
package sevenseg_scan_decoder_pkg;

  // Active-low segment patterns for hex values 0..F, indexed by value.
  localparam logic [6:0] HexSegTable [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,  // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,  // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,  // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E   // C d E F
  };

  typedef enum logic [0:0] {
    StIdle,
    StScan
  } frame_state_e;

  typedef struct packed {
    logic       legal;
    logic [1:0] idx;
  } an_sel_t;

  // Exactly one anode low selects a digit; blank or multi-select is not legal.
  function automatic an_sel_t an_decode(input logic [3:0] an);
    an_sel_t sel;
    case (an)
      4'b1110: sel = '{legal: 1'b1, idx: 2'd0};
      4'b1101: sel = '{legal: 1'b1, idx: 2'd1};
      4'b1011: sel = '{legal: 1'b1, idx: 2'd2};
      4'b0111: sel = '{legal: 1'b1, idx: 2'd3};
      default: sel = '{legal: 1'b0, idx: 2'd0};
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Combinational reverse lookup from an active-low 7-segment pattern to its hex value.
// Ports:
//   i_pattern  7-bit active-low segment pattern (bit0 = a ... bit6 = g)
//   o_value    matching hex value (0 when no match)
//   o_match    high when i_pattern is one of the 16 hex glyphs
module seg7_pattern_lookup
  import sevenseg_scan_decoder_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic [3:0] o_value,
  output logic       o_match
);

  // Table entries are distinct, so at most one iteration hits.
  always_comb begin
    o_value = 4'd0;
    o_match = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i_pattern == HexSegTable[i]) begin
        o_value = 4'(i);
        o_match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Recovers the four hex digits shown on a multiplexed, active-low 7-segment display by
// watching its anode and segment drives. A digit is captured once the {an,seg} pair has
// been stable for STABLE_CYC cycles; a completed four-digit frame raises frame_valid.
// Ports:
//   clk          clock, all state on rising edge
//   reset        asynchronous active-low reset
//   seg_in       active-low segments, bit0 = a ... bit6 = g
//   an_in        active-low digit select, an_in[0] = rightmost digit 0
//   digits       decoded values, digits[4i+3:4i] = digit i
//   digit_valid  bit i set while digit i holds a good capture
//   frame_valid  one-cycle pulse after all four digits were captured without error
//   pattern_err  one-cycle pulse on an unrecognised segment pattern
//   err_digit    digit index of the last pattern_err, held until the next one
module sevenseg_scan_decoder
  import sevenseg_scan_decoder_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 4  // legal range 2..255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        frame_valid,
  output logic        pattern_err,
  output logic [1:0]  err_digit
);

  localparam logic [7:0] CntSat = 8'(STABLE_CYC);
  // Capture fires on the edge the counter steps from here to STABLE_CYC-1.
  localparam logic [7:0] CntArm = 8'(STABLE_CYC - 2);

  logic [10:0] r_in;    // registered {an, seg}
  logic [10:0] r_prev;  // r_in one cycle earlier
  logic [7:0]  r_cnt;

  logic [15:0]  r_digits;
  logic [3:0]   r_digit_valid;
  logic [3:0]   r_seen;
  logic         r_frame_valid;
  logic         r_pattern_err;
  logic [1:0]   r_err_digit;
  frame_state_e r_state;

  an_sel_t    w_sel;
  logic [3:0] w_value;
  logic       w_match;
  logic       w_capture;
  logic       w_good;
  logic       w_bad;

  // Input stage and dwell counter. Reset loads a blank display so any dwell in
  // progress is discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in   <= '1;
      r_prev <= '1;
      r_cnt  <= '0;
    end else begin
      r_prev <= r_in;
      r_in   <= {an_in, seg_in};
      if (r_in != r_prev) begin
        r_cnt <= '0;
      end else if (r_cnt != CntSat) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // Saturation past CntArm guarantees a held input is evaluated only once.
  assign w_capture = (r_in == r_prev) && (r_cnt == CntArm);
  assign w_sel     = an_decode(r_in[10:7]);

  seg7_pattern_lookup u_lookup (
    .i_pattern (r_in[6:0]),
    .o_value   (w_value),
    .o_match   (w_match)
  );

  assign w_good = w_capture & w_sel.legal & w_match;
  assign w_bad  = w_capture & w_sel.legal & ~w_match;

  // Frame FSM with capture bookkeeping. A completing capture and the next capture are
  // always at least two edges apart, so the frame-complete branch never hides one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_digits      <= '0;
      r_digit_valid <= '0;
      r_seen        <= '0;
      r_frame_valid <= 1'b0;
      r_pattern_err <= 1'b0;
      r_err_digit   <= 2'd0;
      r_state       <= StIdle;
    end else begin
      r_frame_valid <= 1'b0;
      r_pattern_err <= 1'b0;
      if ((r_state == StScan) && (r_seen == 4'hF)) begin
        r_frame_valid <= 1'b1;
        r_seen        <= '0;
        r_state       <= StIdle;
      end else if (w_good) begin
        r_digits[{w_sel.idx, 2'b00} +: 4] <= w_value;
        r_digit_valid[w_sel.idx]          <= 1'b1;
        r_seen[w_sel.idx]                 <= 1'b1;
        r_state                           <= StScan;
      end else if (w_bad) begin
        r_pattern_err            <= 1'b1;
        r_err_digit              <= w_sel.idx;
        r_digit_valid[w_sel.idx] <= 1'b0;
        r_seen                   <= '0;
        r_state                  <= StIdle;
      end
    end
  end

  assign digits      = r_digits;
  assign digit_valid = r_digit_valid;
  assign frame_valid = r_frame_valid;
  assign pattern_err = r_pattern_err;
  assign err_digit   = r_err_digit;

endmodule
